// File: rtl/obc_chk_pkg.sv
// rtl/obc_chk_pkg.sv - state encoding and reference answer function for the OBC challenge monitor
package obc_chk_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ASK      = 3'd1,
      WAIT     = 3'd2,
      VERDICT  = 3'd3,
      FAILOVER = 3'd4,
      HALT     = 3'd5
   } state_t;

   // Expected answer to question q, zero-extended to 32 bits and masked to width.
   function automatic logic [31:0] local_answer(input logic [31:0] q, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
      return (q ^ (q << 1) ^ 32'h1) & mask;
   endfunction

endpackage

// File: rtl/lfsr_question_gen.sv
// rtl/lfsr_question_gen.sv - Fibonacci LFSR producing one question per step
module lfsr_question_gen #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] LFSR_SEED = 'h9,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 'hC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (step) q_d = {q_q[WIDTH-2:0], ^(q_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= LFSR_SEED;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/obc_challenge_monitor.sv
// rtl/obc_challenge_monitor.sv - challenge-response watchdog grading the OBC pair and failing over
module obc_challenge_monitor
   import obc_chk_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               ROUNDS      = 10,
   parameter int               PASS_MIN    = 7,
   parameter int               MAX_STRIKES = 3,
   parameter int               TIMEOUT     = 255,
   parameter logic [WIDTH-1:0] LFSR_SEED   = 'h9,
   parameter logic [WIDTH-1:0] LFSR_TAPS   = 'hC
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   output logic [WIDTH-1:0]                   question,
   output logic                               q_valid,
   input  logic [WIDTH-1:0]                   ans_obc,
   input  logic                               ans_valid,
   output logic                               obc_sel,
   output logic                               shutdown_req,
   output logic                               obc_ok,
   output logic [$clog2(MAX_STRIKES+1)-1:0]   strikes,
   output logic                               override
);

   localparam int RW = $clog2(ROUNDS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_STRIKES + 1);
   localparam logic [RW-1:0] ROUND_LAST  = RW'(ROUNDS - 1);
   localparam logic [RW-1:0] ROUNDS_C    = RW'(ROUNDS);
   localparam logic [RW-1:0] PASS_MIN_C  = RW'(PASS_MIN);
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STRIKE_LAST = SW'(MAX_STRIKES - 1);

   state_t          state_q, state_d;
   logic [RW-1:0]   round_q, round_d, correct_q, correct_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [SW-1:0]   strikes_q, strikes_d;
   logic            obc_sel_q, obc_sel_d, obc_ok_q, obc_ok_d, override_q, override_d;
   logic            lfsr_step, ans_match, verdict_pass;

   lfsr_question_gen #(
      .WIDTH     (WIDTH),
      .LFSR_SEED (LFSR_SEED),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_qgen (
      .clk   (clk),
      .reset (reset),
      .step  (lfsr_step),
      .q     (question)
   );

   assign ans_match = (local_answer(32'(question), WIDTH) == 32'(ans_obc));

   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      correct_d    = correct_q;
      timer_d      = timer_q;
      strikes_d    = strikes_q;
      obc_sel_d    = obc_sel_q;
      obc_ok_d     = obc_ok_q;
      override_d   = override_q;
      lfsr_step    = 1'b0;
      q_valid      = 1'b0;
      shutdown_req = 1'b0;
      verdict_pass = 1'b0;
      case (state_q)
         IDLE: begin
            round_d   = '0;
            correct_d = '0;
            timer_d   = '0;
            if (enable) state_d = ASK;
         end
         ASK: begin
            q_valid = 1'b1;
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // An answer arriving on the timeout cycle still counts as an answer.
            if (ans_valid || timer_q == TIMER_LAST) begin
               round_d = round_q + 1'b1;
               if (ans_valid && ans_match) correct_d = correct_q + 1'b1;
               if (round_q == ROUND_LAST) begin
                  state_d = VERDICT;
               end else begin
                  lfsr_step = 1'b1;
                  state_d   = ASK;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         VERDICT: begin
            round_d   = '0;
            correct_d = '0;
            if (correct_q == ROUNDS_C) begin
               verdict_pass = 1'b1;
            end else if (correct_q >= PASS_MIN_C) begin
               strikes_d    = strikes_q + 1'b1;
               verdict_pass = (strikes_q != STRIKE_LAST);
            end
            obc_ok_d = verdict_pass;
            if (verdict_pass) begin
               lfsr_step = 1'b1;
               state_d   = enable ? ASK : IDLE;
            end else begin
               state_d = obc_sel_q ? HALT : FAILOVER;
            end
         end
         FAILOVER: begin
            shutdown_req = 1'b1;
            obc_sel_d    = 1'b1;
            strikes_d    = '0;
            round_d      = '0;
            correct_d    = '0;
            timer_d      = '0;
            state_d      = ASK;
         end
         HALT: begin
            // First HALT cycle carries the single shutdown pulse; override latches after it.
            shutdown_req = ~override_q;
            override_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         round_q    <= '0;
         correct_q  <= '0;
         timer_q    <= '0;
         strikes_q  <= '0;
         obc_sel_q  <= 1'b0;
         obc_ok_q   <= 1'b0;
         override_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         correct_q  <= correct_d;
         timer_q    <= timer_d;
         strikes_q  <= strikes_d;
         obc_sel_q  <= obc_sel_d;
         obc_ok_q   <= obc_ok_d;
         override_q <= override_d;
      end
   end

   assign obc_sel  = obc_sel_q;
   assign obc_ok   = obc_ok_q;
   assign strikes  = strikes_q;
   assign override = override_q;

endmodule

// File: tb/tb_obc_challenge_monitor.sv
// tb/tb_obc_challenge_monitor.sv - directed scenario bench for obc_challenge_monitor
module tb_obc_challenge_monitor;
   import obc_chk_pkg::*;

   localparam int R = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] ans_obc = '0;
   logic       ans_valid = 1'b0;
   logic [3:0] question;
   logic       q_valid, obc_sel, shutdown_req, obc_ok, override;
   logic [1:0] strikes;

   int errors = 0;
   int checks = 0;
   int sd_count = 0;
   logic [3:0] fq, lq;

   obc_challenge_monitor #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .question     (question),
      .q_valid      (q_valid),
      .ans_obc      (ans_obc),
      .ans_valid    (ans_valid),
      .obc_sel      (obc_sel),
      .shutdown_req (shutdown_req),
      .obc_ok       (obc_ok),
      .strikes      (strikes),
      .override     (override)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (shutdown_req === 1'b1) sd_count++;

   function automatic logic [3:0] ref_answer(input logic [3:0] q);
      return {q[2:0] ^ q[3:1], ~q[0]};
   endfunction

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   // Plays the OBC for nrounds rounds; returns at the negedge after the last round ends.
   task automatic run_campaign(input logic [R-1:0] wrong, input int nrounds, input int delay,
                               input bit silent, input bit junk,
                               output logic [3:0] first_q, output logic [3:0] last_q);
      logic [3:0] prev;
      logic       seen_qv;
      int         n;
      bit         timing_ok, seq_ok;
      timing_ok = 1'b1; seq_ok = 1'b1; first_q = '0; last_q = '0; prev = '0; seen_qv = 1'b1;
      for (int r = 0; r < nrounds; r++) begin
         if (r == 0) begin
            n = 0;
            while (q_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
         end
         if (q_valid !== 1'b1) begin timing_ok = 1'b0; seen_qv = q_valid; break; end
         if (r == 0) first_q = question;
         else if (question !== lfsr_next(prev)) seq_ok = 1'b0;
         prev = question; last_q = question;
         if (junk) begin ans_valid = 1'b1; ans_obc = ~ref_answer(question); end
         @(negedge clk);
         ans_valid = 1'b0;
         repeat (delay) @(negedge clk);
         if (!silent) begin
            ans_valid = 1'b1;
            ans_obc = wrong[r] ? (ref_answer(question) ^ 4'h1) : ref_answer(question);
         end
         @(negedge clk);
         ans_valid = 1'b0;
      end
      checks++; if (!timing_ok) begin errors++; $display("FAIL round_timing: q_valid=%b required=1 at round start", seen_qv); end
      checks++; if (!seq_ok) begin errors++; $display("FAIL question_sequence: last question %h does not follow %h", question, prev); end
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; ans_valid = 1'b0; ans_obc = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit fn_ok;
      logic [3:0] qq;
      @(negedge clk);
      checks++; if (question !== 4'h9) begin errors++; $display("FAIL reset_question: got %h required 9", question); end
      checks++; if ({q_valid, obc_sel, shutdown_req, obc_ok, strikes, override} !== 7'b0) begin errors++;
         $display("FAIL reset_outputs: got qv=%b sel=%b sd=%b ok=%b str=%0d ovr=%b required all 0", q_valid, obc_sel, shutdown_req, obc_ok, strikes, override); end
      fn_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         qq = 4'(i);
         if (local_answer(32'(qq), 4) !== 32'(ref_answer(qq))) fn_ok = 1'b0;
      end
      checks++; if (!fn_ok) begin errors++; $display("FAIL local_answer_fn: package function got %h for q=3 required %h", local_answer(32'h3, 4), ref_answer(4'h3)); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (q_valid !== 1'b0 || question !== 4'h9) begin errors++; $display("FAIL idle_hold: got qv=%b q=%h required 0/9", q_valid, question); end
   endtask

   task automatic test_defaults();
      logic [3:0] prev_last;
      bit         any_qv;
      enable = 1'b1;
      run_campaign('0, R, 0, 1'b0, 1'b0, fq, lq);
      checks++; if (fq !== 4'h9) begin errors++; $display("FAIL first_question: got %h required 9", fq); end
      @(negedge clk);
      checks++; if (obc_ok !== 1'b1 || strikes !== 2'd0 || obc_sel !== 1'b0) begin errors++;
         $display("FAIL t1_verdict: got ok=%b str=%0d sel=%b required 1/0/0", obc_ok, strikes, obc_sel); end
      checks++; if (sd_count !== 0) begin errors++; $display("FAIL t1_no_shutdown: got %0d pulses required 0", sd_count); end
      checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL t1_back_to_back: q_valid=%b required 1", q_valid); end
      prev_last = lq;
      enable = 1'b0;
      run_campaign('0, R, 0, 1'b0, 1'b0, fq, lq);
      checks++; if (fq !== lfsr_next(prev_last)) begin errors++; $display("FAIL pass_steps_lfsr: got %h required %h", fq, lfsr_next(prev_last)); end
      @(negedge clk);
      any_qv = 1'b0;
      repeat (5) begin if (q_valid === 1'b1) any_qv = 1'b1; @(negedge clk); end
      checks++; if (any_qv || obc_ok !== 1'b1) begin errors++; $display("FAIL enable_drop_idle: got qv_seen=%b ok=%b required 0/1", any_qv, obc_ok); end
   endtask

   task automatic test_strikes();
      enable = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         run_campaign(10'b0000100100, R, 0, 1'b0, 1'b0, fq, lq);
         @(negedge clk);
         if (c < 3) begin
            checks++; if (strikes !== 2'(c) || obc_ok !== 1'b1 || obc_sel !== 1'b0) begin errors++;
               $display("FAIL strike_%0d: got str=%0d ok=%b sel=%b required %0d/1/0", c, strikes, obc_ok, obc_sel, c); end
         end else begin
            checks++; if (shutdown_req !== 1'b1 || obc_sel !== 1'b0 || obc_ok !== 1'b0) begin errors++;
               $display("FAIL strike_failover: got sd=%b sel=%b ok=%b required 1/0/0", shutdown_req, obc_sel, obc_ok); end
            @(negedge clk);
            checks++; if (obc_sel !== 1'b1 || strikes !== 2'd0 || shutdown_req !== 1'b0) begin errors++;
               $display("FAIL strike_backup: got sel=%b str=%0d sd=%b required 1/0/0", obc_sel, strikes, shutdown_req); end
         end
      end
   endtask

   task automatic test_failover();
      do_reset();
      enable = 1'b1;
      run_campaign(10'b1001001001, R, 0, 1'b0, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (shutdown_req !== 1'b1 || obc_sel !== 1'b0 || strikes !== 2'd0) begin errors++;
         $display("FAIL t3_failover: got sd=%b sel=%b str=%0d required 1/0/0", shutdown_req, obc_sel, strikes); end
      @(negedge clk);
      run_campaign('0, R, 0, 1'b0, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (obc_ok !== 1'b1 || obc_sel !== 1'b1 || strikes !== 2'd0) begin errors++;
         $display("FAIL t3_backup_pass: got ok=%b sel=%b str=%0d required 1/1/0", obc_ok, obc_sel, strikes); end
   endtask

   task automatic test_timeout_halt();
      int  sd_base;
      bit  any_qv, any_sd;
      do_reset();
      enable = 1'b1;
      run_campaign('0, R, 7, 1'b1, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (shutdown_req !== 1'b1 || obc_sel !== 1'b0 || obc_ok !== 1'b0) begin errors++;
         $display("FAIL t4_primary_fail: got sd=%b sel=%b ok=%b required 1/0/0", shutdown_req, obc_sel, obc_ok); end
      @(negedge clk);
      run_campaign('0, R, 7, 1'b1, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (shutdown_req !== 1'b1 || obc_sel !== 1'b1) begin errors++;
         $display("FAIL t4_halt_shutdown: got sd=%b sel=%b required 1/1", shutdown_req, obc_sel); end
      @(negedge clk);
      checks++; if (override !== 1'b1 || shutdown_req !== 1'b0) begin errors++;
         $display("FAIL t4_override_set: got ovr=%b sd=%b required 1/0", override, shutdown_req); end
      sd_base = sd_count;
      any_qv = 1'b0; any_sd = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (q_valid === 1'b1) any_qv = 1'b1;
         if (shutdown_req === 1'b1) any_sd = 1'b1;
      end
      checks++; if (override !== 1'b1 || any_qv || any_sd || sd_count !== sd_base) begin errors++;
         $display("FAIL t4_halt_absorbing: got ovr=%b qv_seen=%b sd_seen=%b required 1/0/0", override, any_qv, any_sd); end
   endtask

   task automatic test_answer_timing();
      do_reset();
      enable = 1'b1;
      run_campaign('0, R, 0, 1'b0, 1'b1, fq, lq);
      @(negedge clk);
      checks++; if (obc_ok !== 1'b1 || strikes !== 2'd0 || obc_sel !== 1'b0) begin errors++;
         $display("FAIL t5_ask_ignored: got ok=%b str=%0d sel=%b required 1/0/0", obc_ok, strikes, obc_sel); end
      run_campaign('0, R, 7, 1'b0, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (obc_ok !== 1'b1 || strikes !== 2'd0 || obc_sel !== 1'b0) begin errors++;
         $display("FAIL t5_answer_wins: got ok=%b str=%0d sel=%b required 1/0/0", obc_ok, strikes, obc_sel); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      enable = 1'b1;
      run_campaign(10'b1001001001, R, 0, 1'b0, 1'b0, fq, lq);
      repeat (2) @(negedge clk);
      run_campaign(10'b0000000001, R, 0, 1'b0, 1'b0, fq, lq);
      @(negedge clk);
      checks++; if (strikes !== 2'd1 || obc_ok !== 1'b1 || obc_sel !== 1'b1) begin errors++;
         $display("FAIL t6_backup_strike: got str=%0d ok=%b sel=%b required 1/1/1", strikes, obc_ok, obc_sel); end
      run_campaign('0, 3, 0, 1'b0, 1'b0, fq, lq);
      checks++; if (q_valid !== 1'b1 || question !== 4'h7) begin errors++;
         $display("FAIL t6_round4_ask: got qv=%b q=%h required 1/7", q_valid, question); end
      reset = 1'b1;
      #1;
      checks++; if (question !== 4'h9 || obc_sel !== 1'b0) begin errors++;
         $display("FAIL t6_reset_q_sel: got q=%h sel=%b required 9/0", question, obc_sel); end
      checks++; if ({q_valid, shutdown_req, obc_ok, strikes, override} !== 6'b0) begin errors++;
         $display("FAIL t6_reset_outputs: got qv=%b sd=%b ok=%b str=%0d ovr=%b required all 0", q_valid, shutdown_req, obc_ok, strikes, override); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_strikes();
      test_failover();
      test_timeout_halt();
      test_answer_timing();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
